// File: rtl/sram_controller_pkg.sv
// rtl/sram_controller_pkg.sv - shared state encoding and data-memory base address
package sram_controller_pkg;

  localparam int unsigned BASE_ADDR = 1024;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

endpackage

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit load/store responder over a 16-bit asynchronous SRAM
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned BASE_ADDR     = sram_controller_pkg::BASE_ADDR,
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned SRAM_AW       = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);

  localparam int unsigned PW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [PW-1:0] LAST = PW'(ACCESS_CYCLES - 1);

  state_t             state, state_n;
  logic [PW-1:0]      phase;
  logic [SRAM_AW-2:0] word_q;
  logic [31:0]        wdata_q;
  logic [31:0]        off;
  logic               last;
  logic               drive;
  logic [15:0]        dq_out;
  logic               unused_off;

  assign off        = address - 32'(BASE_ADDR);
  assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};
  assign last       = (phase == LAST);

  assign ready   = (state == DONE) || (state == IDLE && !rd_en && !wr_en);
  assign SRAM_DQ = drive ? dq_out : 16'bz;

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (wr_en) state_n = WR_LO;
               else if (rd_en) state_n = RD_LO;
      RD_LO:   if (last) state_n = RD_HI;
      RD_HI:   if (last) state_n = DONE;
      WR_LO:   if (last) state_n = WR_HI;
      WR_HI:   if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // WE_N rises on the final cycle of each write half so address and data are held past the write.
  always_comb begin
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    drive     = 1'b0;
    dq_out    = wdata_q[15:0];
    case (state)
      RD_LO: SRAM_ADDR = {word_q, 1'b0};
      RD_HI: SRAM_ADDR = {word_q, 1'b1};
      WR_LO: begin
        SRAM_ADDR = {word_q, 1'b0};
        SRAM_WE_N = last;
        drive     = 1'b1;
      end
      WR_HI: begin
        SRAM_ADDR = {word_q, 1'b1};
        SRAM_WE_N = last;
        drive     = 1'b1;
        dq_out    = wdata_q[31:16];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      read_data <= '0;
    end else begin
      state <= state_n;
      phase <= (state_n != state || state == IDLE) ? '0 : phase + 1'b1;
      if (state == RD_LO && last) read_data[15:0]  <= SRAM_DQ;
      if (state == RD_HI && last) read_data[31:16] <= SRAM_DQ;
    end
  end

  // Request operands are frozen for the whole access once IDLE is left.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      word_q  <= off[SRAM_AW:2];
      wdata_q <= write_data;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - self-checking bench for sram_controller with behavioural SRAM
module tb_sram_controller;

  localparam int AC   = 2;
  localparam int AW   = 18;
  localparam int BASE = 1024;
  localparam int LAT  = 2 * AC + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data;
  wire  [31:0] read_data;
  wire         ready;
  wire  [15:0] SRAM_DQ;
  wire  [AW-1:0] SRAM_ADDR;
  wire         SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N;

  always #5 clk = ~clk;

  sram_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(AC), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N)
  );

  // Behavioural async SRAM; the probe drives zeros so any controller drive shows up on the bus.
  logic [15:0] mem [0:(1<<AW)-1];
  bit tb_drive = 1'b0;
  bit tb_probe = 1'b0;
  assign SRAM_DQ = tb_drive ? (tb_probe ? 16'h0000 : mem[SRAM_ADDR]) : 16'bz;

  always @(posedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;

  logic [31:0] ref_mem [int unsigned];
  int unsigned written[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic probe_z(input string tag);
    tb_drive = 1'b1;
    tb_probe = 1'b1;
    #1;
    chk(tag, {16'h0, SRAM_DQ}, 32'h0);
    tb_drive = 1'b0;
    tb_probe = 1'b0;
  endtask

  function automatic int unsigned word_of(input logic [31:0] a);
    logic [31:0] o;
    o = a - 32'(BASE);
    return (o >> 2) & ((1 << (AW - 1)) - 1);
  endfunction

  // One request: checks latency, per-cycle bus activity, stored/loaded data.
  task automatic run_op(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                        input bit hold_after, input bit chain, input string nm);
    int unsigned wi;
    int cnt;
    wi = word_of(a);
    tb_probe   = 1'b0;
    tb_drive   = r && !w;
    rd_en      = r;
    wr_en      = w;
    address    = a;
    write_data = d;
    if (chain) @(negedge clk);
    else #1;
    chk({nm, "_req_ready"}, {31'b0, ready}, 32'h0);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        address    = $urandom;
        write_data = $urandom;
      end
      if (cnt <= 2 * AC && !ready) begin
        chk({nm, "_addr"}, 32'(SRAM_ADDR), (cnt <= AC) ? 32'(wi * 2) : 32'(wi * 2 + 1));
        chk({nm, "_we_n"}, {31'b0, SRAM_WE_N}, (w && (cnt % AC) != 0) ? 32'h0 : 32'h1);
        if (w) chk({nm, "_dq"}, {16'h0, SRAM_DQ}, (cnt <= AC) ? {16'h0, d[15:0]} : {16'h0, d[31:16]});
      end
    end while (!ready && cnt < 12);
    chk({nm, "_latency"}, 32'(cnt), 32'(LAT));
    if (w) begin
      ref_mem[wi] = d;
      written.push_back(wi);
      chk({nm, "_mem_lo"}, {16'h0, mem[wi * 2]}, {16'h0, d[15:0]});
      chk({nm, "_mem_hi"}, {16'h0, mem[wi * 2 + 1]}, {16'h0, d[31:16]});
    end else begin
      chk({nm, "_rdata"}, read_data, ref_mem[wi]);
    end
    if (!hold_after) begin
      rd_en    = 1'b0;
      wr_en    = 1'b0;
      tb_drive = 1'b0;
      @(negedge clk);
      chk({nm, "_idle_ready"}, {31'b0, ready}, 32'h1);
      chk({nm, "_idle_we_n"}, {31'b0, SRAM_WE_N}, 32'h1);
    end
  endtask

  bit          do_wr;
  logic [31:0] ra;
  int unsigned rw;

  initial begin
    rst = 1'b1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    address = '0;
    write_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", {31'b0, ready}, 32'h1);
    chk("rst_we_n", {31'b0, SRAM_WE_N}, 32'h1);
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_addr", 32'(SRAM_ADDR), 32'h0);
    chk("tied_pins", {28'h0, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N}, 32'h0);
    probe_z("rst_dq_z");

    run_op(1, 0, 32'd1024, 32'hDEAD_BEEF, 0, 0, "st_base");
    run_op(0, 1, 32'd1024, 32'h0, 0, 0, "ld_base");
    chk("ld_base_value", read_data, 32'hDEAD_BEEF);
    run_op(1, 0, 32'd1036, 32'h1234_5678, 0, 0, "st_1036");
    chk("st_1036_sram6", {16'h0, mem[6]}, 32'h5678);
    run_op(0, 1, 32'd1036, 32'h0, 0, 0, "ld_1036");
    chk("ld_1036_value", read_data, 32'h1234_5678);
    run_op(1, 1, 32'd1040, 32'hA5A5_0F0F, 1, 0, "both");
    chk("both_sram8", {16'h0, mem[8]}, 32'h0F0F);
    run_op(0, 1, 32'd1024, 32'h0, 0, 1, "b2b_ld");
    chk("b2b_value", read_data, 32'hDEAD_BEEF);

    // Reset lands on the third cycle of a write (IDLE cycle counted first).
    tb_drive = 1'b0;
    wr_en = 1'b1;
    address = 32'd1044;
    write_data = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wr_en = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {31'b0, ready}, 32'h1);
    chk("mid_rst_we_n", {31'b0, SRAM_WE_N}, 32'h1);
    chk("mid_rst_addr", 32'(SRAM_ADDR), 32'h0);
    probe_z("mid_rst_dq_z");
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdata", read_data, 32'h0);

    for (int i = 0; i < 24; i++) begin
      do_wr = (written.size() == 0) || ($urandom_range(0, 1) == 1);
      if (do_wr) begin
        ra = 32'(BASE) + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
        run_op(1, bit'($urandom_range(0, 1)), ra, $urandom, 0, 0, "rnd_wr");
      end else begin
        rw = written[$urandom_range(0, written.size() - 1)];
        ra = 32'(BASE) + 32'(rw * 4) + 32'($urandom_range(0, 3));
        run_op(0, 1, ra, $urandom, 0, 0, "rnd_rd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
